pc_fetch_unit: RTL

//   Consumer end of the next-PC path. Holds the architectural PC, loads the next-PC value

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg : shared fetch-path types and constants                            |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_unit : architectural PC register and req/gnt/rvalid fetch FSM     |
// | Optional: FETCH_MISALIGN_CHK_EN traps misaligned PCs instead of fetching   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] npc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_add4,
  output logic [31:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              fetch_misalign
);

  fetch_state_t      r_state, w_nxt_state;
  logic [ADDR_W-1:0] r_pc, w_nxt_pc;
  logic [31:0]       r_inst, w_nxt_inst;
  logic              r_valid, w_nxt_valid;
  logic              r_req;
  logic              w_gnt;
  logic              w_nxt_blocked;
`ifdef FETCH_MISALIGN_CHK_EN
  logic              r_mis, w_nxt_mis;
`endif

  // A grant only counts while a request is actually presented.
  assign w_gnt = r_req & imem_gnt;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = r_pc;
    w_nxt_inst  = r_inst;
    w_nxt_valid = r_valid;
`ifdef FETCH_MISALIGN_CHK_EN
    w_nxt_mis   = r_mis;
`endif
    case (r_state)
      FETCH: begin
        if (w_gnt) w_nxt_state = WAIT;
`ifdef FETCH_MISALIGN_CHK_EN
        if (r_pc[1:0] != 2'b00) begin
          w_nxt_state = HOLD;
          w_nxt_inst  = NOP_INST;
          w_nxt_valid = 1'b1;
          w_nxt_mis   = 1'b1;
        end
`endif
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_nxt_state = HOLD;
          w_nxt_inst  = imem_rdata;
          w_nxt_valid = 1'b1;
        end
      end
      HOLD: begin
        if (r_valid && inst_ready) begin
          w_nxt_state = FETCH;
          w_nxt_pc    = npc;
          w_nxt_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
          w_nxt_mis   = 1'b0;
`endif
        end
      end
      DRAIN: begin
        if (imem_rvalid) w_nxt_state = FETCH;
      end
    endcase

    // Redirect wins; an in-flight response must still be swallowed.
    if (flush) begin
      w_nxt_pc    = flush_pc;
      w_nxt_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      w_nxt_mis   = 1'b0;
`endif
      case (r_state)
        FETCH:   w_nxt_state = w_gnt ? DRAIN : FETCH;
        WAIT:    w_nxt_state = imem_rvalid ? FETCH : DRAIN;
        HOLD:    w_nxt_state = FETCH;
        DRAIN:   w_nxt_state = imem_rvalid ? FETCH : DRAIN;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_nxt_blocked  = (w_nxt_pc[1:0] != 2'b00);
  assign fetch_misalign = r_mis;
`else
  assign w_nxt_blocked  = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_pc    <= w_nxt_pc;
      r_inst  <= w_nxt_inst;
      r_valid <= w_nxt_valid;
      r_req   <= (w_nxt_state == FETCH) && !w_nxt_blocked;
`ifdef FETCH_MISALIGN_CHK_EN
      r_mis   <= w_nxt_mis;
`endif
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = {r_pc[ADDR_W-1:2], 2'b00};
  assign pc         = r_pc;
  assign pc_add4    = r_pc + ADDR_W'(4);
  assign inst       = r_inst;
  assign inst_valid = r_valid;

endmodule
`default_nettype wire
